// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Storage is an unreset register array; only the pointers and the occupancy count carry reset state.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Pointer arithmetic relies on natural wrap of an AW-bit counter.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("fifo_sync: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s;
    logic             pop_s;

    // Handshake outputs are decoded from the count register only, so there is no ready/valid loop.
    assign wr_ready = (count_q < CW'(DEPTH));
    assign rd_valid = (count_q != {CW{1'b0}});
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    assign push_s = wr_valid && wr_ready && !flush;
    assign pop_s  = rd_valid && rd_ready && !flush;

    // Next-state computation for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset outranks flush and any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
